alarm_ctrl: RTL and testbench

//  Alarm unit for the digital clock. Holds a user-set BCD alarm time (HH:MM),

---
 rtl/alarm_ctrl.sv | 129 ++++++++++++
 tb/tb_alarm_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Alarm unit: stores a BCD HH:MM alarm time, compares it with the running time on each
// 1 Hz tick, and drives the buzzer enable with snooze and stop control.
module alarm_ctrl #(
   parameter int unsigned RING_SECS   = 60,
   parameter int unsigned SNOOZE_SECS = 300,
   parameter logic [15:0] ALARM_RST   = 16'h0700
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick_1hz,
   input  logic [15:0] cur_time,
   input  logic        sec_zero,
   input  logic        arm_en,
   input  logic        set_en,
   input  logic [15:0] set_time,
   input  logic        snooze,
   input  logic        stop,
   output logic [15:0] alarm_time,
   output logic        ringing,
   output logic        snoozing,
   output logic        set_err
);

   localparam logic [7:0]  RING_LD = 8'(RING_SECS);
   localparam logic [15:0] SNZ_LD  = 16'(SNOOZE_SECS);

   typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_e;

   state_e      state, state_nxt;
   logic [7:0]  ring_cnt, ring_cnt_nxt;
   logic [15:0] snz_cnt, snz_cnt_nxt;
   logic [15:0] alarm_nxt;
   logic        ringing_nxt, snoozing_nxt, set_err_nxt;
   logic        set_ok, set_load, match;

   // BCD legality: 00..23 hours, 00..59 minutes
   always_comb begin
      set_ok = (set_time[15:12] <= 4'd2) && (set_time[11:8] <= 4'd9) &&
               ((set_time[15:12] != 4'd2) || (set_time[11:8] <= 4'd3)) &&
               (set_time[7:4] <= 4'd5) && (set_time[3:0] <= 4'd9);
      set_load = set_en & set_ok;
      match    = tick_1hz & sec_zero & (cur_time == alarm_time);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ring_cnt   <= '0;
         snz_cnt    <= '0;
         alarm_time <= ALARM_RST;
         ringing    <= 1'b0;
         snoozing   <= 1'b0;
         set_err    <= 1'b0;
      end else begin
         state      <= state_nxt;
         ring_cnt   <= ring_cnt_nxt;
         snz_cnt    <= snz_cnt_nxt;
         alarm_time <= alarm_nxt;
         ringing    <= ringing_nxt;
         snoozing   <= snoozing_nxt;
         set_err    <= set_err_nxt;
      end
   end

   // Disarm and a legal set both cancel everything; buttons outrank tick expiry
   always_comb begin
      state_nxt    = state;
      ring_cnt_nxt = ring_cnt;
      snz_cnt_nxt  = snz_cnt;
      if (!arm_en || set_load) begin
         state_nxt    = IDLE;
         ring_cnt_nxt = '0;
         snz_cnt_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (match) begin
                  state_nxt    = RINGING;
                  ring_cnt_nxt = RING_LD;
               end
            end
            RINGING: begin
               if (stop) begin
                  state_nxt    = IDLE;
                  ring_cnt_nxt = '0;
               end else if (snooze) begin
                  state_nxt    = SNOOZE;
                  ring_cnt_nxt = '0;
                  snz_cnt_nxt  = SNZ_LD;
               end else if (tick_1hz) begin
                  if (ring_cnt <= 8'd1) begin
                     state_nxt    = IDLE;
                     ring_cnt_nxt = '0;
                  end else begin
                     ring_cnt_nxt = ring_cnt - 8'd1;
                  end
               end
            end
            SNOOZE: begin
               if (stop) begin
                  state_nxt   = IDLE;
                  snz_cnt_nxt = '0;
               end else if (tick_1hz) begin
                  if (snz_cnt <= 16'd1) begin
                     state_nxt    = RINGING;
                     ring_cnt_nxt = RING_LD;
                     snz_cnt_nxt  = '0;
                  end else begin
                     snz_cnt_nxt = snz_cnt - 16'd1;
                  end
               end
            end
            default: begin
               state_nxt    = IDLE;
               ring_cnt_nxt = '0;
               snz_cnt_nxt  = '0;
            end
         endcase
      end
   end

   always_comb begin
      ringing_nxt  = (state_nxt == RINGING);
      snoozing_nxt = (state_nxt == SNOOZE);
      set_err_nxt  = set_en & ~set_ok;
      alarm_nxt    = set_load ? set_time : alarm_time;
   end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: expected outputs are queued as each cycle is driven
// and compared one clock later by a monitor.
module tb_alarm_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick_1hz = 1'b0;
   logic [15:0] cur_time = 16'h0000;
   logic        sec_zero = 1'b0;
   logic        arm_en = 1'b1;
   logic        set_en = 1'b0;
   logic [15:0] set_time = 16'h0000;
   logic        snooze = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] alarm_time;
   logic        ringing, snoozing, set_err;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      string       tag;
      logic        r, s, e;
      logic [15:0] t;
   } exp_t;
   exp_t sb[$];

   alarm_ctrl #(.RING_SECS(3), .SNOOZE_SECS(2), .ALARM_RST(16'h0700)) dut (
      .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .cur_time(cur_time),
      .sec_zero(sec_zero), .arm_en(arm_en), .set_en(set_en), .set_time(set_time),
      .snooze(snooze), .stop(stop), .alarm_time(alarm_time), .ringing(ringing),
      .snoozing(snoozing), .set_err(set_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         chk({x.tag, ".ring"},  32'(ringing),    32'(x.r));
         chk({x.tag, ".snz"},   32'(snoozing),   32'(x.s));
         chk({x.tag, ".err"},   32'(set_err),    32'(x.e));
         chk({x.tag, ".alarm"}, 32'(alarm_time), 32'(x.t));
      end
   end

   // Inputs already driven at a negedge; queue expectation, clock once, clear pulses
   task automatic step(input string tag, input logic er, input logic es, input logic ee,
                       input logic [15:0] et);
      sb.push_back('{tag, er, es, ee, et});
      @(posedge clk);
      @(negedge clk);
      tick_1hz = 1'b0; sec_zero = 1'b0; cur_time = 16'h0000;
      set_en = 1'b0; snooze = 1'b0; stop = 1'b0;
   endtask

   task automatic tk(input logic [15:0] t, input logic sz);
      tick_1hz = 1'b1; cur_time = t; sec_zero = sz;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst.ring", 32'(ringing), 32'd0);
      chk("rst.snz", 32'(snoozing), 32'd0);
      chk("rst.err", 32'(set_err), 32'd0);
      chk("rst.alarm", 32'(alarm_time), 32'h0700);
      rst_n = 1'b1;
      @(negedge clk);

      step("idle", 0, 0, 0, 16'h0700);
      set_en = 1; set_time = 16'h2360; step("set_bad_min", 0, 0, 1, 16'h0700);
      step("err_pulse", 0, 0, 0, 16'h0700);
      set_en = 1; set_time = 16'h2400; step("set_bad_hr", 0, 0, 1, 16'h0700);
      set_en = 1; set_time = 16'h2359; step("set_ok", 0, 0, 0, 16'h2359);
      set_en = 1; set_time = 16'h0700; step("set_back", 0, 0, 0, 16'h0700);

      tk(16'h0700, 0); step("no_sec0", 0, 0, 0, 16'h0700);
      arm_en = 0; tk(16'h0700, 1); step("disarmed", 0, 0, 0, 16'h0700);
      arm_en = 1; tk(16'h0701, 1); step("wrong_min", 0, 0, 0, 16'h0700);

      tk(16'h0700, 1); step("match", 1, 0, 0, 16'h0700);
      step("ring_hold", 1, 0, 0, 16'h0700);
      tk(16'h0700, 0); step("ring_t1", 1, 0, 0, 16'h0700);
      tk(16'h0700, 0); step("ring_t2", 1, 0, 0, 16'h0700);
      tk(16'h0700, 0); step("ring_t3", 0, 0, 0, 16'h0700);

      tk(16'h0700, 1); step("match2", 1, 0, 0, 16'h0700);
      snooze = 1; step("snooze", 0, 1, 0, 16'h0700);
      step("snz_hold", 0, 1, 0, 16'h0700);
      tk(16'h0700, 0); step("snz_t1", 0, 1, 0, 16'h0700);
      snooze = 1; step("snz_ignored", 0, 1, 0, 16'h0700);
      tk(16'h0700, 0); step("snz_t2", 1, 0, 0, 16'h0700);
      stop = 1; step("stop", 0, 0, 0, 16'h0700);

      tk(16'h0700, 1); step("match3", 1, 0, 0, 16'h0700);
      stop = 1; snooze = 1; step("stop_snz", 0, 0, 0, 16'h0700);

      tk(16'h0700, 1); set_en = 1; set_time = 16'h0700; step("set_in_match", 0, 0, 0, 16'h0700);

      tk(16'h0700, 1); step("match4", 1, 0, 0, 16'h0700);
      snooze = 1; step("snooze2", 0, 1, 0, 16'h0700);
      arm_en = 0; step("disarm_snz", 0, 0, 0, 16'h0700);
      arm_en = 1;

      tk(16'h0700, 1); step("match5", 1, 0, 0, 16'h0700);
      tk(16'h0000, 0); step("r5_t1", 1, 0, 0, 16'h0700);
      tk(16'h0700, 1); step("no_retrig", 1, 0, 0, 16'h0700);
      tk(16'h0000, 0); step("r5_t3", 0, 0, 0, 16'h0700);

      tk(16'h0700, 1); step("match6", 1, 0, 0, 16'h0700);
      tk(16'h0000, 0); step("r6_t1", 1, 0, 0, 16'h0700);
      tk(16'h0000, 0); step("r6_t2", 1, 0, 0, 16'h0700);
      tk(16'h0000, 0); snooze = 1; step("btn_wins", 0, 1, 0, 16'h0700);
      tk(16'h0000, 0); step("s6_t1", 0, 1, 0, 16'h0700);
      tk(16'h0000, 0); stop = 1; step("stop_wins", 0, 0, 0, 16'h0700);

      tk(16'h0700, 1); step("match7", 1, 0, 0, 16'h0700);
      set_en = 1; set_time = 16'h0800; step("set_cancels", 0, 0, 0, 16'h0800);
      tk(16'h0800, 1); step("match8", 1, 0, 0, 16'h0800);

      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst.ring", 32'(ringing), 32'd0);
      chk("async_rst.alarm", 32'(alarm_time), 32'h0700);
      chk("async_rst.snz", 32'(snoozing), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      step("post_rst", 0, 0, 0, 16'h0700);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
